// File: rtl/rect_fill.sv
// rect_fill: fills an inclusive rectangle on the VGA adapter framebuffer,
// one pixel per clock, in column-major order (y inner, x outer).
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start             level request, only sampled in IDLE
//   x0,y0,x1,y1       inclusive corners; x1/y1 are clipped to the screen
//   colour_a/b        primary / secondary colour
//   mode              0,3 solid; 1 checkerboard; 2 outline
//   busy, done        status: busy while filling, done held until start drops
//   vga_x/y/colour    registered pixel presented to the adapter
//   vga_plot          write strobe; pixel fields are meaningful only when high
//
// Handshake: start is a level. It is accepted only in IDLE. After the last
// pixel the block sits in DONE with done=1 for as long as start stays high,
// and returns to IDLE on the first edge with start=0, so a held start never
// retriggers a second fill.
module rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour_a,
  input  logic [CW-1:0] colour_b,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] ca_q, ca_d, cb_q, cb_d;
  logic [XW-1:0] x0_q, x0_d, ex_q, ex_d;
  logic [YW-1:0] y0_q, y0_d, ey_q, ey_d;
  logic [XW-1:0] vga_x_q, vga_x_d;
  logic [YW-1:0] vga_y_q, vga_y_d;
  logic [CW-1:0] vga_colour_q, vga_colour_d;
  logic          vga_plot_q, vga_plot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Request-side clipped corners, used only when accepting in IDLE.
  logic [XW-1:0] ex_in;
  logic [YW-1:0] ey_in;
  logic          empty_in;
  logic [CW:0]   pix;  // {plot, colour} for the pixel about to be presented

  // Plot/colour of one pixel; checker parity uses absolute coordinates.
  function automatic logic [CW:0] pixel_of(
    input logic [1:0]    m,
    input logic [CW-1:0] ca,
    input logic [CW-1:0] cb,
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input logic [XW-1:0] lx,
    input logic [YW-1:0] ty,
    input logic [XW-1:0] rx,
    input logic [YW-1:0] by
  );
    logic          p;
    logic [CW-1:0] c;
    p = 1'b1;
    c = ca;
    case (m)
      2'd1:    c = (x[0] ^ y[0]) ? cb : ca;
      2'd2:    p = (x == lx) || (x == rx) || (y == ty) || (y == by);
      default: ;
    endcase
    return {p, c};
  endfunction

  always_comb begin
    ex_in    = (x1 > X_MAX) ? X_MAX : x1;
    ey_in    = (y1 > Y_MAX) ? Y_MAX : y1;
    empty_in = (x0 > ex_in) || (y0 > ey_in) || (x0 > X_MAX) || (y0 > Y_MAX);

    state_d      = state_q;
    mode_d       = mode_q;
    ca_d         = ca_q;
    cb_d         = cb_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = done_q;
    pix          = '0;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          mode_d = mode;
          ca_d   = colour_a;
          cb_d   = colour_b;
          x0_d   = x0;
          y0_d   = y0;
          ex_d   = ex_in;
          ey_d   = ey_in;
          if (empty_in) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = S_FILL;
            busy_d       = 1'b1;
            vga_x_d      = x0;
            vga_y_d      = y0;
            pix          = pixel_of(mode, colour_a, colour_b, x0, y0,
                                    x0, y0, ex_in, ey_in);
            vga_plot_d   = pix[CW];
            vga_colour_d = pix[CW-1:0];
          end
        end
      end
      S_FILL: begin
        busy_d = 1'b1;
        // Counters only advance while strictly below the clipped bound, so
        // they never wrap even when x1/y1 sit at the top of their range.
        if (vga_y_q < ey_q) begin
          vga_y_d = vga_y_q + 1'b1;
        end else if (vga_x_q < ex_q) begin
          vga_x_d = vga_x_q + 1'b1;
          vga_y_d = y0_q;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        if (state_d == S_FILL) begin
          pix          = pixel_of(mode_q, ca_q, cb_q, vga_x_d, vga_y_d,
                                  x0_q, y0_q, ex_q, ey_q);
          vga_plot_d   = pix[CW];
          vga_colour_d = pix[CW-1:0];
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      ca_q         <= '0;
      cb_q         <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      ex_q         <= '0;
      ey_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ca_q         <= ca_d;
      cb_q         <= cb_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: full clear, clipping, empty regions,
// checker/outline pixels, start/done handshake and mid-fill reset.
module tb_rect_fill;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic [CW-1:0] colour_a, colour_b;
  logic [1:0]    mode;
  logic          busy, done, vga_plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  int n_assert = 0;
  int n_fail   = 0;

  rect_fill dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .colour_a(colour_a), .colour_b(colour_b), .mode(mode),
    .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {plot, colour} of pixel (x,y) in a region.
  function automatic logic [CW:0] exp_pix(input int m, input int x, input int y,
                                          input int lx, input int ty, input int rx,
                                          input int by, input logic [CW-1:0] ca,
                                          input logic [CW-1:0] cb);
    if (m == 1) return {1'b1, (((x ^ y) & 1) != 0) ? cb : ca};
    if (m == 2) return {(x == lx || x == rx || y == ty || y == by), ca};
    return {1'b1, ca};
  endfunction

  // Request a fill and follow it pixel by pixel; start stays high afterwards.
  task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int ex, input int ey, input int m,
                          input logic [CW-1:0] ca, input logic [CW-1:0] cb,
                          input string tag);
    int           nplot;
    logic [CW:0]  p;
    logic [XW-1:0] xe;
    logic [YW-1:0] ye;
    x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
    mode = 2'(m); colour_a = ca; colour_b = cb;
    start = 1'b1;
    tick();
    nplot = 0;
    for (int x = ax0; x <= ex; x++) begin
      for (int y = ay0; y <= ey; y++) begin
        p  = exp_pix(m, x, y, ax0, ay0, ex, ey, ca, cb);
        xe = XW'(x);
        ye = YW'(y);
        chk({tag, "_pix"}, 32'({busy, done, vga_plot, vga_x, vga_y, vga_colour}),
            32'({1'b1, 1'b0, p[CW], xe, ye, p[CW-1:0]}));
        if (vga_plot) nplot++;
        // scribble on the request inputs mid-fill; they must be ignored
        x0 = XW'($urandom_range(0, 255)); x1 = XW'($urandom_range(0, 255));
        mode = 2'($urandom_range(0, 3));
        if (!(x == ex && y == ey)) tick();
      end
    end
    tick();
    chk({tag, "_end"}, 32'({busy, done, vga_plot}), 32'(3'b010));
    chk({tag, "_nplot"}, 32'(nplot),
        32'((m == 2) ? ((ex - ax0 + 1) * (ey - ay0 + 1)
                        - ((ex - ax0 - 1 > 0 ? ex - ax0 - 1 : 0) * (ey - ay0 - 1 > 0 ? ey - ay0 - 1 : 0)))
                     : (ex - ax0 + 1) * (ey - ay0 + 1)));
  endtask

  logic [CW-1:0] chk_col [9];
  logic [8:0]    out_plot;

  initial begin
    rst = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    colour_a = '0; colour_b = '0; mode = '0;
    chk_col = '{3'b110, 3'b001, 3'b110, 3'b001, 3'b110, 3'b001, 3'b110, 3'b001, 3'b110};
    out_plot = 9'b111_101_111;

    // reset state
    #12;
    chk("reset_outs", 32'({busy, done, vga_plot, vga_x, vga_y, vga_colour}), 32'(0));
    rst = 1'b0;
    tick();
    chk("idle_outs", 32'({busy, done, vga_plot}), 32'(0));

    // full-screen clear: 19200 pixels, done after edge k+19200
    run_fill(0, 0, 159, 119, 159, 119, 0, 3'b000, 3'b000, "clear");
    start = 1'b0;
    tick();
    chk("clear_idle", 32'(done), 32'(0));

    // clipped region
    run_fill(150, 110, 255, 127, 159, 119, 0, 3'b101, 3'b000, "clip");
    start = 1'b0;
    tick();

    // empty regions
    x0 = 8'd5; y0 = 7'd5; x1 = 8'd4; y1 = 7'd9; mode = 2'd0; start = 1'b1;
    tick();
    chk("empty1", 32'({busy, done, vga_plot}), 32'(3'b010));
    start = 1'b0;
    tick();
    chk("empty1_idle", 32'(done), 32'(0));
    x0 = 8'd200; y0 = 7'd5; x1 = 8'd210; y1 = 7'd9; start = 1'b1;
    tick();
    chk("empty2", 32'({busy, done, vga_plot}), 32'(3'b010));
    start = 1'b0;
    tick();

    // checkerboard (2,3)-(4,5)
    x0 = 8'd2; y0 = 7'd3; x1 = 8'd4; y1 = 7'd5;
    colour_a = 3'b001; colour_b = 3'b110; mode = 2'd1; start = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("checker_pix", 32'({vga_x, vga_y, vga_plot, vga_colour}),
          32'({8'(2 + i / 3), 7'(3 + i % 3), 1'b1, chk_col[i]}));
      tick();
    end
    chk("checker_done", 32'({busy, done}), 32'(2'b01));
    start = 1'b0;
    tick();

    // outline (2,3)-(4,5): 8 plots over 9 scan cycles
    mode = 2'd2; start = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("outline_pix", 32'({vga_x, vga_y, vga_plot, vga_colour, busy}),
          32'({8'(2 + i / 3), 7'(3 + i % 3), out_plot[8 - i], 3'b001, 1'b1}));
      tick();
    end
    chk("outline_done", 32'({busy, done, vga_plot}), 32'(3'b010));

    // held start: done stays, no retrigger
    for (int i = 0; i < 50; i++) begin
      chk("hold_done", 32'({busy, done, vga_plot}), 32'(3'b010));
      tick();
    end
    start = 1'b0;
    tick();
    chk("drop_start", 32'({busy, done}), 32'(0));
    run_fill(10, 10, 11, 12, 11, 12, 0, 3'b011, 3'b000, "refill");
    start = 1'b0;
    tick();

    // reset at pixel 37 of a full clear
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd159; y1 = 7'd119; mode = 2'd0;
    colour_a = 3'b111; start = 1'b1;
    tick();
    for (int i = 0; i < 37; i++) tick();
    chk("pix37", 32'({vga_x, vga_y, vga_plot}), 32'({8'd0, 7'd37, 1'b1}));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({busy, done, vga_plot, vga_x, vga_y, vga_colour}), 32'(0));
    start = 1'b0;
    #20 rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'({busy, done, vga_plot}), 32'(0));
    run_fill(0, 0, 159, 119, 159, 119, 0, 3'b010, 3'b000, "clear2");
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
